// File: rtl/maf_channel_scheduler.sv
// Shared moving-average datapath time-multiplexed across NUM_CH channels.
// Each channel owns a circular history slice in one RAM, a running sum and a fill counter.
module maf_channel_scheduler #(
    parameter int NUM_CH        = 8,
    parameter int WINDOW_LENGTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
    output logic [NUM_CH-1:0]              in_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_CH)-1:0]      out_ch,
    input  logic                           flush,
    output logic                           busy
);

    localparam int CW    = $clog2(NUM_CH);
    localparam int LW    = $clog2(WINDOW_LENGTH);
    localparam int SW    = DATA_WIDTH + LW + 1;
    localparam int AW    = CW + LW;
    localparam int DEPTH = NUM_CH * WINDOW_LENGTH;
    localparam logic [LW:0]   FULL    = (LW+1)'(WINDOW_LENGTH);
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        UPDATE = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t                        state_r;
    logic [NUM_CH-1:0]             pend_r;
    logic [DATA_WIDTH-1:0]         pend_data_r [NUM_CH];
    logic signed [SW-1:0]          sum_r       [NUM_CH];
    logic [LW-1:0]                 wptr_r      [NUM_CH];
    logic [LW:0]                   fill_r      [NUM_CH];
    logic [CW-1:0]                 last_r;
    logic [CW-1:0]                 gnt_r;
    logic [DATA_WIDTH-1:0]         cur_r;
    logic                          out_valid_r;
    logic [DATA_WIDTH-1:0]         out_data_r;
    logic [CW-1:0]                 out_ch_r;
    logic [DATA_WIDTH-1:0]         ram_r [DEPTH];
    logic [DATA_WIDTH-1:0]         ram_rdata_r;

    logic                          grant_found_s;
    logic [CW-1:0]                 grant_idx_s;
    logic [AW-1:0]                 addr_s;
    logic [DATA_WIDTH-1:0]         old_s;
    logic signed [SW-1:0]          sum_next_s;
    logic                          ram_we_s;

    // Round-robin search starting just above the last granted channel.
    function automatic logic [CW:0] rr_pick(input logic [NUM_CH-1:0] req,
                                            input logic [CW-1:0]     last);
        logic          found;
        logic [CW-1:0] idx;
        int            cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = int'(last) + i;
            cand = (cand >= NUM_CH) ? (cand - NUM_CH) : cand;
            if (!found && req[CW'(cand)]) begin
                found = 1'b1;
                idx   = CW'(cand);
            end
        end
        return {found, idx};
    endfunction

    // Arbitration, RAM addressing and the running-sum update for the granted channel.
    always_comb begin
        {grant_found_s, grant_idx_s} = rr_pick(pend_r, last_r);
        addr_s   = {gnt_r, wptr_r[gnt_r]};
        ram_we_s = (state_r == UPDATE) && !flush;
        if (fill_r[gnt_r] == FULL) begin
            old_s = ram_rdata_r;
        end else begin
            old_s = '0;
        end
        sum_next_s = sum_r[gnt_r]
                   + $signed({{(SW-DATA_WIDTH){cur_r[DATA_WIDTH-1]}}, cur_r})
                   - $signed({{(SW-DATA_WIDTH){old_s[DATA_WIDTH-1]}}, old_s});
    end

    // Single-port history RAM: write in UPDATE, otherwise a synchronous read.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[addr_s] <= cur_r;
        end else begin
            ram_rdata_r <= ram_r[addr_s];
        end
    end

    // Capture, arbitration and datapath FSM; flush clears the same state as rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            pend_r      <= '0;
            last_r      <= LAST_CH;
            gnt_r       <= '0;
            cur_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pend_data_r[c] <= '0;
                sum_r[c]       <= '0;
                wptr_r[c]      <= '0;
                fill_r[c]      <= '0;
            end
        end else if (flush) begin
            state_r     <= IDLE;
            pend_r      <= '0;
            last_r      <= LAST_CH;
            gnt_r       <= '0;
            cur_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                pend_data_r[c] <= '0;
                sum_r[c]       <= '0;
                wptr_r[c]      <= '0;
                fill_r[c]      <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_valid[c] && !pend_r[c]) begin
                    pend_r[c]      <= 1'b1;
                    pend_data_r[c] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        // Copy the sample out so the slot can refill while we work.
                        pend_r[grant_idx_s] <= 1'b0;
                        gnt_r               <= grant_idx_s;
                        last_r              <= grant_idx_s;
                        cur_r               <= pend_data_r[grant_idx_s];
                        state_r             <= READ;
                    end
                end
                READ: begin
                    state_r <= UPDATE;
                end
                UPDATE: begin
                    sum_r[gnt_r]  <= sum_next_s;
                    wptr_r[gnt_r] <= wptr_r[gnt_r] + LW'(1);
                    if (fill_r[gnt_r] != FULL) begin
                        fill_r[gnt_r] <= fill_r[gnt_r] + (LW+1)'(1);
                    end
                    // Bit slice equals sum >>> LW truncated: floor division by the window.
                    out_data_r  <= sum_next_s[LW +: DATA_WIDTH];
                    out_ch_r    <= gnt_r;
                    out_valid_r <= 1'b1;
                    state_r     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = ~pend_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign busy      = (state_r != IDLE) || (|pend_r);

endmodule
